ei_axi4_slave_mem: RTL and testbench

- Synthesizable AXI4 slave memory. Sits directly downstream of the VIP master driver on the AXI4 pin interface.
- Gives the bench a real DUT that consumes AW/W/AR traffic and produces B/R responses.
- Write and read paths are independent FSMs sharing one byte-addressable word array.
- Supports FIXED, INCR and WRAP bursts, byte strobes and SLVERR reporting.

---
 rtl/ei_axi4_slave_mem_if.sv | 62 ++++++
 rtl/ei_axi4_slave_mem.sv | 207 ++++++++++++++++++++
 tb/tb_ei_axi4_slave_mem.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ei_axi4_slave_mem_if.sv
// AXI4 pin bundle between a master driver and ei_axi4_slave_mem.
// Only the five channels are carried here; clock and reset stay as plain ports.
interface ei_axi4_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs over one word array,
// FIXED/INCR/WRAP bursts, byte strobes, SLVERR on malformed or out-of-range bursts.
module ei_axi4_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input logic                aclk,
    input logic                areset,
    ei_axi4_slave_mem_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam int EW    = ADDR_WIDTH + 16;
    localparam logic [EW-1:0] E1    = EW'(1);
    localparam logic [EW-1:0] LIMIT = EW'(MEM_DEPTH) * EW'(BYTES);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    localparam addr_t A1 = addr_t'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [IDXW-1:0] widx(input addr_t a);
        return a[IDXW+BSH-1:BSH];
    endfunction

    function automatic addr_t next_addr(input addr_t a, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        addr_t step, wsz;
        step = A1 << size;
        wsz  = addr_t'({1'b0, len} + 9'd1) << size;
        case (burst)
            2'b01:   next_addr = (a & ~(step - A1)) + step;
            2'b10:   next_addr = (a & ~(wsz - A1)) | ((a + step) & (wsz - A1));
            default: next_addr = a;
        endcase
    endfunction

    // Whole-burst check done up front, so beat 0 of a read already knows its rresp.
    // Range is judged on the highest address the burst can touch, computed without wrap.
    function automatic logic burst_err(input addr_t a, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [EW-1:0] step, span, base, last;
        logic          bad;
        step = E1 << size;
        span = EW'({1'b0, len} + 9'd1) << size;
        base = EW'(a) & ~(span - E1);
        last = EW'(a);
        bad  = (size > 3'(BSH)) || (burst == 2'b11) || (EW'(a) >= LIMIT);
        if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            bad = 1'b1;
        case (burst)
            2'b01:   last = (EW'(a) & ~(step - E1)) + EW'(len) * step;
            2'b10:   last = base + span - E1;
            default: last = EW'(a);
        endcase
        if (last >= LIMIT)
            bad = 1'b1;
        return bad;
    endfunction

    // ---------------- write path ----------------
    wstate_t     w_state, w_nxt;
    addr_t       w_addr;
    logic [7:0]  w_len, w_cnt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_bad, w_proto, w_proto_nxt;
    logic        aw_hs, w_hs, b_hs, w_last_beat, aw_err;

    always_comb begin
        w_nxt       = w_state;
        aw_hs       = bus.awvalid & bus.awready;
        w_hs        = bus.wvalid & bus.wready;
        b_hs        = bus.bvalid & bus.bready;
        w_last_beat = (w_cnt == w_len);
        w_proto_nxt = w_proto | (w_hs & (bus.wlast != w_last_beat));
        aw_err      = burst_err(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
        case (w_state)
            W_IDLE:  if (aw_hs) w_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_nxt = W_RESP;
            W_RESP:  if (b_hs) w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state, so ready only rises
    // on the first edge after reset is released.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state     <= W_IDLE;
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_bad       <= 1'b0;
            w_proto     <= 1'b0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
        end else begin
            w_state     <= w_nxt;
            bus.awready <= (w_nxt == W_IDLE);
            bus.wready  <= (w_nxt == W_DATA);
            bus.bvalid  <= (w_nxt == W_RESP);
            if (aw_hs) begin
                w_addr  <= bus.awaddr;
                w_len   <= bus.awlen;
                w_size  <= bus.awsize;
                w_burst <= bus.awburst;
                w_cnt   <= '0;
                w_bad   <= aw_err;
                w_proto <= 1'b0;
            end
            if (w_hs) begin
                w_proto <= w_proto_nxt;
                w_cnt   <= w_cnt + 8'd1;
                w_addr  <= next_addr(w_addr, w_len, w_size, w_burst);
            end
            if (w_hs && w_last_beat)
                bus.bresp <= (w_bad | w_proto_nxt) ? 2'b10 : 2'b00;
            else if (b_hs)
                bus.bresp <= 2'b00;
        end
    end

    // A protocol (wlast) error still lets data land; only address/burst errors block it.
    always_ff @(posedge aclk) begin
        if (!areset && w_hs && !w_bad) begin
            for (int i = 0; i < BYTES; i++)
                if (bus.wstrb[i])
                    mem[widx(w_addr)][i*8 +: 8] <= bus.wdata[i*8 +: 8];
        end
    end

    // ---------------- read path ----------------
    rstate_t     r_state, r_nxt;
    addr_t       r_addr, r_next_addr;
    logic [7:0]  r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_bad, ar_hs, r_hs, ar_err;

    always_comb begin
        r_nxt       = r_state;
        ar_hs       = bus.arvalid & bus.arready;
        r_hs        = bus.rvalid & bus.rready;
        ar_err      = burst_err(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
        r_next_addr = next_addr(r_addr, r_len, r_size, r_burst);
        case (r_state)
            R_IDLE:  if (ar_hs) r_nxt = R_DATA;
            R_DATA:  if (r_hs && bus.rlast) r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    // rdata is fetched with a non-blocking read, so a write to the same word on
    // the same edge is not visible until the next fetch.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_bad       <= 1'b0;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rresp   <= 2'b00;
            bus.rdata   <= '0;
        end else begin
            r_state     <= r_nxt;
            bus.arready <= (r_nxt == R_IDLE);
            bus.rvalid  <= (r_nxt == R_DATA);
            if (ar_hs) begin
                r_addr    <= bus.araddr;
                r_len     <= bus.arlen;
                r_size    <= bus.arsize;
                r_burst   <= bus.arburst;
                r_cnt     <= '0;
                r_bad     <= ar_err;
                bus.rdata <= ar_err ? '0 : mem[widx(bus.araddr)];
                bus.rresp <= ar_err ? 2'b10 : 2'b00;
                bus.rlast <= (bus.arlen == 8'd0);
            end else if (r_hs) begin
                if (bus.rlast) begin
                    bus.rdata <= '0;
                    bus.rresp <= 2'b00;
                    bus.rlast <= 1'b0;
                end else begin
                    r_addr    <= r_next_addr;
                    r_cnt     <= r_cnt + 8'd1;
                    bus.rdata <= r_bad ? '0 : mem[widx(r_next_addr)];
                    bus.rlast <= ((r_cnt + 8'd1) == r_len);
                end
            end
        end
    end
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed bench for ei_axi4_slave_mem: byte-level memory model, per-cycle B/R
// compare against model queues, plus literal spot values.
module tb_ei_axi4_slave_mem;
    localparam int DW = 32, AW = 32, DEPTH = 1024, LIMIT = DEPTH * 4;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    ei_axi4_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ei_axi4_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    int          n_chk = 0, n_pass = 0;
    logic [7:0]  mm [0:LIMIT-1];
    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];
    logic [31:0] got_r[$];
    logic [1:0]  got_b[$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    bit          rr_toggle = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", nm, got, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: event not seen within bound", nm);
    endtask

    // ---------------- model ----------------
    function automatic logic [31:0] beat_addr(input logic [31:0] a0, input int len, input int size,
                                              input logic [1:0] burst, input int n);
        logic [31:0] step, w, base;
        step = 32'd1 << size;
        case (burst)
            INCR: return (n == 0) ? a0 : (a0 & ~(step - 32'd1)) + step * 32'(n);
            WRAP: begin
                w    = step * 32'(len + 1);
                base = a0 - (a0 % w);
                return base + ((a0 - base + step * 32'(n)) % w);
            end
            default: return a0;
        endcase
    endfunction

    function automatic bit burst_bad(input logic [31:0] a0, input int len, input int size,
                                     input logic [1:0] burst);
        if (size > 2 || burst == 2'b11) return 1;
        if (burst == WRAP && !(len inside {1, 3, 7, 15})) return 1;
        for (int n = 0; n <= len; n++)
            if (beat_addr(a0, len, size, burst, n) >= LIMIT) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFFC;
        return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < got_r.size()) return got_r[i];
        return 'x;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge aclk) begin
        if (!areset) begin
            if (bus.bvalid) begin
                if (exp_b.size() == 0) fail_now("unexpected_bvalid");
                else begin
                    chk("bresp", bus.bresp, exp_b[0]);
                    if (bus.bready) begin
                        got_b.push_back(bus.bresp);
                        void'(exp_b.pop_front());
                    end
                end
            end
            if (bus.rvalid) begin
                if (exp_r.size() == 0) fail_now("unexpected_rvalid");
                else begin
                    chk("rdata", bus.rdata, exp_r[0].data);
                    chk("rresp", bus.rresp, exp_r[0].resp);
                    chk("rlast", bus.rlast, exp_r[0].last);
                    if (bus.rready) begin
                        got_r.push_back(bus.rdata);
                        void'(exp_r.pop_front());
                    end
                end
            end
        end
    end

    always @(posedge aclk) begin
        #1;
        if (rr_toggle) bus.rready = ~bus.rready;
    end

    // ---------------- drivers ----------------
    task automatic write_burst(input logic [31:0] a, input int len, input int size,
                               input logic [1:0] burst, input int bad_last);
        bit          bad;
        logic [31:0] ad;
        int          k;
        bad = burst_bad(a, len, size, burst);
        if (!bad)
            for (int n = 0; n <= len; n++) begin
                ad = beat_addr(a, len, size, burst, n) & 32'hFFFF_FFFC;
                for (int j = 0; j < 4; j++)
                    if (ws[n][j]) mm[ad + 32'(j)] = wd[n][j*8 +: 8];
            end
        exp_b.push_back((bad || bad_last >= 0) ? 2'b10 : 2'b00);
        bus.awaddr = a; bus.awlen = 8'(len); bus.awsize = 3'(size); bus.awburst = burst;
        bus.awvalid = 1'b1;
        k = 0;
        do begin @(negedge aclk); k++; end while (!bus.awready && k < 50);
        if (!bus.awready) begin fail_now("aw_handshake"); bus.awvalid = 1'b0; return; end
        @(posedge aclk); #1 bus.awvalid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            bus.wdata = wd[n]; bus.wstrb = ws[n];
            bus.wlast = (n == len) ^ (n == bad_last);
            bus.wvalid = 1'b1;
            k = 0;
            do begin @(negedge aclk); k++; end while (!bus.wready && k < 50);
            if (!bus.wready) begin fail_now("w_handshake"); bus.wvalid = 1'b0; return; end
            @(posedge aclk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        @(negedge aclk);
        chk("b_latency", bus.bvalid, 1'b1);
    endtask

    task automatic exp_read(input logic [31:0] a, input int len, input int size, input logic [1:0] burst);
        bit     bad;
        rbeat_t b;
        bad = burst_bad(a, len, size, burst);
        for (int n = 0; n <= len; n++) begin
            b.data = bad ? 32'h0 : model_word(beat_addr(a, len, size, burst, n));
            b.resp = bad ? 2'b10 : 2'b00;
            b.last = (n == len);
            exp_r.push_back(b);
        end
    endtask

    task automatic ar_req(input logic [31:0] a, input int len, input int size, input logic [1:0] burst);
        int k;
        bus.araddr = a; bus.arlen = 8'(len); bus.arsize = 3'(size); bus.arburst = burst;
        bus.arvalid = 1'b1;
        k = 0;
        do begin @(negedge aclk); k++; end while (!bus.arready && k < 50);
        if (!bus.arready) begin fail_now("ar_handshake"); bus.arvalid = 1'b0; return; end
        @(posedge aclk); #1 bus.arvalid = 1'b0;
        @(negedge aclk);
        chk("r_latency", bus.rvalid, 1'b1);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && k < 300) begin
            @(negedge aclk); k++;
        end
        if (exp_r.size() != 0 || exp_b.size() != 0) begin
            n_chk++;
            $display("FAIL %s: %0d R and %0d B responses outstanding, expected 0",
                     nm, exp_r.size(), exp_b.size());
            exp_r.delete(); exp_b.delete();
        end
        @(posedge aclk); #1;
    endtask

    task automatic rd(input logic [31:0] a, input int len, input int size, input logic [1:0] burst);
        got_r.delete();
        exp_read(a, len, size, burst);
        ar_req(a, len, size, burst);
        wait_done("read_done");
    endtask

    task automatic wr(input logic [31:0] a, input int len, input int size,
                      input logic [1:0] burst, input int bad_last);
        got_b.delete();
        write_burst(a, len, size, burst, bad_last);
        wait_done("write_done");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, bus.awready, 1'b0);
        chk({tag, "_wready"},  bus.wready,  1'b0);
        chk({tag, "_bvalid"},  bus.bvalid,  1'b0);
        chk({tag, "_bresp"},   bus.bresp,   2'b00);
        chk({tag, "_arready"}, bus.arready, 1'b0);
        chk({tag, "_rvalid"},  bus.rvalid,  1'b0);
        chk({tag, "_rlast"},   bus.rlast,   1'b0);
        chk({tag, "_rresp"},   bus.rresp,   2'b00);
        chk({tag, "_rdata"},   bus.rdata,   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < LIMIT; i++) mm[i] = 8'h00;
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;

        // reset state and release timing
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk_reset_outputs("rst");
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("awready_before_edge", bus.awready, 1'b0);
        @(negedge aclk);
        chk("awready_after_release", bus.awready, 1'b1);
        chk("arready_after_release", bus.arready, 1'b1);
        @(posedge aclk); #1;

        // fill 0x00..0xFF with a known pattern
        for (int blk = 0; blk < 4; blk++) begin
            for (int n = 0; n < 16; n++) begin
                wd[n] = 32'hA5A5_0000 | 32'(blk * 16 + n);
                ws[n] = 4'hF;
            end
            wr(32'(blk * 64), 15, 2, INCR, -1);
        end

        // single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr(32'h10, 0, 2, INCR, -1);
        chk("single_bresp", got_b.size() ? got_b[0] : 2'bxx, 2'b00);
        rd(32'h10, 0, 2, INCR);
        chk("single_rdata", got_at(0), 32'hDEADBEEF);

        // INCR with strobes, read back under rready toggling
        wd[0] = 1; wd[1] = 2; wd[2] = 3; wd[3] = 4;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'h3; ws[3] = 4'hF;
        wr(32'h40, 3, 2, INCR, -1);
        got_r.delete();
        rr_toggle = 1;
        exp_read(32'h40, 3, 2, INCR);
        ar_req(32'h40, 3, 2, INCR);
        wait_done("toggle_read");
        rr_toggle = 0; bus.rready = 1'b1;
        chk("incr_b0", got_at(0), 32'h1);
        chk("incr_b1", got_at(1), 32'h2);
        chk("incr_b2_strobe", got_at(2), 32'hA5A50003);
        chk("incr_b3", got_at(3), 32'h4);

        // WRAP placement
        chk("wrap_a0", beat_addr(32'h38, 3, 2, WRAP, 0), 32'h38);
        chk("wrap_a1", beat_addr(32'h38, 3, 2, WRAP, 1), 32'h3C);
        chk("wrap_a2", beat_addr(32'h38, 3, 2, WRAP, 2), 32'h30);
        chk("wrap_a3", beat_addr(32'h38, 3, 2, WRAP, 3), 32'h34);
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int n = 0; n < 4; n++) ws[n] = 4'hF;
        wr(32'h38, 3, 2, WRAP, -1);
        rd(32'h30, 3, 2, INCR);
        chk("wrap_30", got_at(0), 32'h33);
        chk("wrap_34", got_at(1), 32'h44);
        chk("wrap_38", got_at(2), 32'h11);
        chk("wrap_3c", got_at(3), 32'h22);
        for (int n = 0; n < 3; n++) wd[n] = 32'hBAD0_0000 | 32'(n);
        wr(32'h38, 2, 2, WRAP, -1);
        chk("wrap_len2_bresp", got_b.size() ? got_b[0] : 2'bxx, 2'b10);
        rd(32'h30, 3, 2, INCR);
        chk("wrap_len2_unchanged", got_at(0), 32'h33);

        // error bursts
        wd[0] = 32'h0BAD_0BAD; ws[0] = 4'hF;
        wr(32'h50, 0, 3, INCR, -1);
        chk("size3_bresp", got_b.size() ? got_b[0] : 2'bxx, 2'b10);
        rd(32'h50, 0, 2, INCR);
        chk("size3_unchanged", got_at(0), 32'hA5A50014);
        rd(32'h1000, 3, 2, INCR);
        chk("oor_beats", got_r.size(), 4);
        chk("oor_b3_data", got_at(3), 32'h0);
        rd(32'h0, 0, 3, INCR);
        rd(32'h0, 1, 2, 2'b11);
        for (int n = 0; n < 4; n++) begin wd[n] = 32'(n + 5); ws[n] = 4'hF; end
        wr(32'h60, 3, 2, INCR, 1);
        chk("wlast_early_bresp", got_b.size() ? got_b[0] : 2'bxx, 2'b10);

        // concurrent write and read to the same word
        got_r.delete(); got_b.delete();
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        exp_read(32'h20, 0, 2, INCR);
        fork
            write_burst(32'h20, 0, 2, INCR, -1);
            ar_req(32'h20, 0, 2, INCR);
        join
        wait_done("concurrent");
        chk("concurrent_old", got_at(0), 32'hA5A50008);
        rd(32'h20, 0, 2, INCR);
        chk("concurrent_new", got_at(0), 32'hCAFEF00D);

        // reset in the middle of an 8-beat read
        got_r.delete();
        exp_read(32'h80, 7, 2, INCR);
        ar_req(32'h80, 7, 2, INCR);
        k = 0;
        while (got_r.size() < 2 && k < 50) begin @(negedge aclk); k++; end
        if (got_r.size() < 2) fail_now("reset_read_beats");
        @(posedge aclk); #1 areset = 1'b1;
        exp_r.delete();
        @(posedge aclk);
        @(negedge aclk);
        chk_reset_outputs("midrst");
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("midrst_arready_pre", bus.arready, 1'b0);
        @(negedge aclk);
        chk("midrst_arready", bus.arready, 1'b1);
        chk("midrst_rvalid", bus.rvalid, 1'b0);
        @(posedge aclk); #1;
        rd(32'h80, 7, 2, INCR);
        chk("retain_80", got_at(0), 32'hA5A50020);
        rd(32'h10, 0, 2, FIXED);
        chk("retain_10", got_at(0), 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
